// File: rtl/fetch_queue_if.sv
// Bundle of the fetch->queue push handshake and the queue->decode pop port.
//
// Handshake: the push side is valid/ready. A pair of packets moves on a
// rising clk edge exactly when push_valid_i & push_ready_o are both high
// (and no flush is requested). push_ready_o never depends on push_valid_i,
// so the producer may wait for ready before raising valid or do the reverse.
// The pop side is credit-free: decode sees up to two valid slots and
// reports in pop_count_i how many it consumes this cycle.
interface fetch_queue_if #(
  parameter int PKT_W = 65,
  parameter int CNT_W = 4
);
  logic [2*PKT_W-1:0] push_data_i;
  logic               push_valid_i;
  logic               push_ready_o;
  logic [2*PKT_W-1:0] pop_data_o;
  logic [1:0]         pop_valid_o;
  logic [1:0]         pop_count_i;
  logic               flush_i;
  logic [CNT_W-1:0]   count_o;
  logic               err_o;

  // Environment side: fetch, decode and the redirect logic.
  modport master (
    output push_data_i, push_valid_i, pop_count_i, flush_i,
    input  push_ready_o, pop_data_o, pop_valid_o, count_o, err_o
  );

  // Queue side.
  modport slave (
    input  push_data_i, push_valid_i, pop_count_i, flush_i,
    output push_ready_o, pop_data_o, pop_valid_o, count_o, err_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-in / two-out instruction queue between fetch and decode.
// Circular buffer with head/tail pointers and a registered occupancy count.
// Packets enter strictly in pairs; decode retires 0, 1 or 2 per cycle.
module fetch_queue #(
  parameter int PC_BITS    = 32,
  parameter int INSTR_BITS = 32,
  parameter int DEPTH      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.slave  bus
);
  localparam int PKT_W = PC_BITS + INSTR_BITS + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW-1:0]    head_nxt, tail_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             push_ready, push_fire;
  logic [1:0]       pop_req, pop_eff;
  logic             pop_err;

  // Ready looks only at the registered count so it never combinationally
  // depends on what decode does this cycle.
  assign push_ready = (count_q <= CW'(DEPTH - 2));
  assign push_fire  = bus.push_valid_i & push_ready & ~bus.flush_i;
  assign head_nxt   = head_q + AW'(1);
  assign tail_nxt   = tail_q + AW'(1);

  // Clamp the retire request to what is actually held; flag over-pops.
  always_comb begin
    pop_req = (bus.pop_count_i == 2'd3) ? 2'd2 : bus.pop_count_i;
    pop_eff = pop_req;
    if (CW'(pop_req) > count_q) pop_eff = count_q[1:0];
    pop_err = (bus.pop_count_i == 2'd3) | (CW'(bus.pop_count_i) > count_q);
  end

  // Next pointers/count; flush wins over push and pop, error flag is sticky.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q | pop_err;
    if (bus.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop_eff);
      tail_d  = push_fire ? (tail_q + AW'(2)) : tail_q;
      count_d = count_q + (push_fire ? CW'(2) : CW'(0)) - CW'(pop_eff);
    end
  end

  // Pointer, count and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Packet storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[tail_q]   <= bus.push_data_i[PKT_W-1:0];
      mem_q[tail_nxt] <= bus.push_data_i[2*PKT_W-1:PKT_W];
    end
  end

  assign bus.push_ready_o = push_ready;
  assign bus.pop_valid_o  = {(count_q >= CW'(2)), (count_q != '0)};
  assign bus.pop_data_o   = {mem_q[head_nxt], mem_q[head_q]};
  assign bus.count_o      = count_q;
  assign bus.err_o        = err_q;
endmodule
